// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Number of CHUNK-bit slices processed per operation.
  function automatic int num_chunks(int width, int chunk);
    return width / chunk;
  endfunction

  // Counter width, never zero so a single-slice build still has a legal vector.
  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_unit_if.sv
// Board-side bundle: buttons/switches in, operand/result registers and status out.
interface chunked_adder_unit_if #(
    parameter int WIDTH = 16
);
    logic             LoadB;
    logic             Run;
    logic [1:0]       Mode;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Sum;
    logic             Co;
    logic             Busy;
    logic             Done;

    modport master (
        output LoadB, Run, Mode, SW,
        input  A, B, Sum, Co, Busy, Done
    );

    modport slave (
        input  LoadB, Run, Mode, SW,
        output A, B, Sum, Co, Busy, Done
    );
endinterface

// File: rtl/chunked_adder_unit_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder, reused once per clock by the unit.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[CHUNK];
endmodule

// File: rtl/chunked_adder_unit.sv
// Sequential add/subtract/accumulate: one CHUNK-bit slice per clock, LSB slice first.
module chunked_adder_unit
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    chunked_adder_unit_if.slave   bus
);
    localparam int N  = num_chunks(WIDTH, CHUNK);
    localparam int KW = cnt_width(N);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             co_q, co_d, done_q, done_d, run_q;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] opx_q, opx_d, opy_q, opy_d, res_q, res_d;
    logic             carry_q, carry_d;
    logic [CHUNK-1:0] slice_s;
    logic             slice_c;
    logic             start;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x    (opx_q[CHUNK-1:0]),
        .y    (opy_q[CHUNK-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    assign start = run_q & ~bus.Run;

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path
        // through the case statement can leave a signal unassigned and infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        co_d    = co_q;
        done_d  = 1'b0;
        k_d     = k_q;
        opx_d   = opx_q;
        opy_d   = opy_q;
        res_d   = res_q;
        carry_d = carry_q;

        case (state_q)
            IDLE: begin
                if (!bus.LoadB) b_d = bus.SW;
                else            a_d = bus.SW;
                if (start) begin
                    state_d = CALC;
                    k_d     = '0;
                    case (bus.Mode)
                        MODE_SUB: begin opx_d = a_q;   opy_d = ~b_q; carry_d = 1'b1; end
                        MODE_ACC: begin opx_d = sum_q; opy_d = a_q;  carry_d = 1'b0; end
                        default:  begin opx_d = a_q;   opy_d = b_q;  carry_d = 1'b0; end
                    endcase
                end
            end
            CALC: begin
                // Operands shift down so slice 0 always feeds the adder; results enter at the top.
                opx_d   = opx_q >> CHUNK;
                opy_d   = opy_q >> CHUNK;
                res_d   = (res_q >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));
                carry_d = slice_c;
                k_d     = KW'(k_q + 1'b1);
                if (k_q == KW'(N - 1)) begin
                    sum_d   = res_d;
                    co_d    = slice_c;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    k_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, matching the combinational next-state computed above.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
            k_q     <= '0;
            run_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            done_q  <= done_d;
            k_q     <= k_d;
            run_q   <= bus.Run;
        end
    end

    // NOTE: the datapath shift registers carry no reset; they are always loaded
    // at start before CALC reads them, and nothing outside sees their contents.
    always_ff @(posedge Clk) begin
        opx_q   <= opx_d;
        opy_q   <= opy_d;
        res_q   <= res_d;
        carry_q <= carry_d;
    end

    assign bus.A    = a_q;
    assign bus.B    = b_q;
    assign bus.Sum  = sum_q;
    assign bus.Co   = co_q;
    assign bus.Busy = (state_q == CALC);
    assign bus.Done = done_q;
endmodule

// File: tb/tb_chunked_adder_unit.sv
// Directed self-checking bench for chunked_adder_unit at WIDTH=16, CHUNK=4.
module tb_chunked_adder_unit;
    logic Clk;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    chunked_adder_unit_if #(.WIDTH(16)) bus ();

    chunked_adder_unit #(.WIDTH(16), .CHUNK(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Loads B via LoadB, then leaves SW at a so A tracks it.
    task automatic load(input logic [15:0] a, input logic [15:0] b);
        bus.LoadB = 1'b0; bus.SW = b; tick();
        bus.LoadB = 1'b1; bus.SW = a; tick();
    endtask

    // One Run press; reports cycles from start edge to Done and Busy-high cycles.
    task automatic run_op(output int lat, output int busy_cyc);
        lat = 0; busy_cyc = 0;
        bus.Run = 1'b0; tick();
        bus.Run = 1'b1;
        while (!bus.Done && lat < 12) begin
            if (bus.Busy) busy_cyc++;
            tick();
            lat++;
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_A"},    32'(bus.A),    32'h0);
        check({tag, "_B"},    32'(bus.B),    32'h0);
        check({tag, "_Sum"},  32'(bus.Sum),  32'h0);
        check({tag, "_Co"},   32'(bus.Co),   32'h0);
        check({tag, "_Busy"}, 32'(bus.Busy), 32'h0);
        check({tag, "_Done"}, 32'(bus.Done), 32'h0);
    endtask

    initial begin
        int lat, busy_cyc, done_cnt;

        Reset = 1'b0; bus.Run = 1'b1; bus.LoadB = 1'b1; bus.Mode = 2'b00; bus.SW = 16'h0;
        tick(); tick();
        check_cleared("reset");
        Reset = 1'b1;

        load(16'h1234, 16'h4321);
        check("load_A", 32'(bus.A), 32'h1234);
        check("load_B", 32'(bus.B), 32'h4321);
        run_op(lat, busy_cyc);
        check("add1_latency", 32'(lat),      32'd4);
        check("add1_busy",    32'(busy_cyc), 32'd4);
        check("add1_sum",     32'(bus.Sum),  32'h5555);
        check("add1_co",      32'(bus.Co),   32'h0);
        check("add1_busy_end",32'(bus.Busy), 32'h0);
        tick();
        check("add1_done_pulse", 32'(bus.Done), 32'h0);

        load(16'hFFFF, 16'h0001);
        run_op(lat, busy_cyc);
        check("add2_sum", 32'(bus.Sum), 32'h0000);
        check("add2_co",  32'(bus.Co),  32'h1);

        bus.Mode = 2'b11;
        load(16'h0F0F, 16'h00F1);
        run_op(lat, busy_cyc);
        check("mode3_sum", 32'(bus.Sum), 32'h1000);
        check("mode3_co",  32'(bus.Co),  32'h0);

        bus.Mode = 2'b01;
        load(16'h0007, 16'h0005);
        run_op(lat, busy_cyc);
        check("sub1_sum", 32'(bus.Sum), 32'h0002);
        check("sub1_co",  32'(bus.Co),  32'h1);
        load(16'h0005, 16'h0007);
        run_op(lat, busy_cyc);
        check("sub2_sum", 32'(bus.Sum), 32'hFFFE);
        check("sub2_co",  32'(bus.Co),  32'h0);

        Reset = 1'b0; tick(); Reset = 1'b1;
        bus.Mode = 2'b10; bus.SW = 16'h0003; tick();
        run_op(lat, busy_cyc);
        check("acc1_sum", 32'(bus.Sum), 32'h0003);
        run_op(lat, busy_cyc);
        check("acc2_sum", 32'(bus.Sum), 32'h0006);
        run_op(lat, busy_cyc);
        check("acc3_sum", 32'(bus.Sum), 32'h0009);
        check("acc3_co",  32'(bus.Co),  32'h0);

        bus.Mode = 2'b00;
        load(16'h1111, 16'h2222);
        bus.Run = 1'b0; tick();
        bus.Run = 1'b1; tick();
        Reset = 1'b0; tick();
        check_cleared("abort");
        Reset = 1'b1; bus.SW = 16'h0000;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.Done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        load(16'h1111, 16'h2222);
        run_op(lat, busy_cyc);
        check("post_abort_sum", 32'(bus.Sum), 32'h3333);
        check("post_abort_co",  32'(bus.Co),  32'h0);

        load(16'h00F0, 16'h000F);
        done_cnt = 0;
        bus.Run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.Done) done_cnt++;
            if (i == 1) begin bus.LoadB = 1'b0; bus.SW = 16'hABCD; end
            if (i == 3) begin bus.LoadB = 1'b1; bus.SW = 16'h00F0; end
        end
        bus.Run = 1'b1; tick();
        check("hold_done_count", 32'(done_cnt), 32'd1);
        check("hold_B_frozen",   32'(bus.B),    32'h000F);
        check("hold_sum",        32'(bus.Sum),  32'h00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
